pc_stack: RTL and testbench

PC_STACK -- requirements
Module: pc_stack

---
 rtl/pic_pkg.sv | 8 +
 rtl/stack_ptr.sv | 63 ++++++
 rtl/pc_stack.sv | 85 ++++++++
 tb/tb_pc_stack.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared PIC definitions: program counter width and return-stack depth.
// Used by pc_stack defaults and by the PIC top level.
package pic_pkg;

    localparam int PC_W        = 9;
    localparam int STACK_DEPTH = 2;

endpackage

// File: rtl/stack_ptr.sv
// Return-stack pointer: modular write pointer plus saturating occupancy.
// Ports: clk_i, rst_i, push_i, pop_i -> wp_o (next write slot),
//        top_o (current top slot), count_o, empty_o, full_o.
module stack_ptr
    import pic_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    output logic [PW-1:0] wp_o,
    output logic [PW-1:0] top_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    logic [PW-1:0] wp_q, wp_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wp_inc, wp_dec;

    // Explicit wrap so non-power-of-two depths stay modular.
    assign wp_inc = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
    assign wp_dec = (wp_q == '0) ? PW'(DEPTH - 1) : wp_q - 1'b1;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign wp_o    = wp_q;
    assign top_o   = wp_dec;
    assign count_o = count_q;

    always_comb begin
        wp_d    = wp_q;
        count_d = count_q;
        if (push_i && !pop_i) begin
            wp_d = wp_inc;
            if (!full_o) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop_i && !push_i) begin
            // Underflow still rewinds wp so stale data wraps onto the bus.
            wp_d = wp_dec;
            if (!empty_o) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// PIC hardware return-address stack: circular storage, top read, error flags.
// Ports: clk, rst, push, pop, push_data, clr_flags -> stack_bus, count,
//        empty, full, ovf (push while full), unf (pop while empty).
module pc_stack
    import pic_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int PC_W  = pic_pkg::PC_W,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    input  logic            clr_flags,
    output logic [PC_W-1:0] stack_bus,
    output logic [CW-1:0]   count,
    output logic            empty,
    output logic            full,
    output logic            ovf,
    output logic            unf
);

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   top;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            ovf_set, unf_set;

    stack_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wp_o    (wp),
        .top_o   (top),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    // Combinational top read so the PC mux can use it during the pop cycle.
    assign stack_bus = mem_q[top];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && pop) begin
            // Simultaneous call/return replaces the top in place.
            mem_q[top] <= push_data;
        end else if (push) begin
            mem_q[wp] <= push_data;
        end
    end

    assign ovf_set = push && !pop && full;
    assign unf_set = pop && !push && empty;

    // Set wins over a coincident clear.
    always_comb begin
        ovf_d = (ovf_q && !clr_flags) || ovf_set;
        unf_d = (unf_q && !clr_flags) || unf_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed cases plus random traffic
// compared each cycle against a behavioural stack model.
module tb_pc_stack;

    localparam int D  = 2;
    localparam int W  = 9;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [W-1:0]  push_data = '0;
    logic          clr_flags = 1'b0;
    logic [W-1:0]  stack_bus;
    logic [CW-1:0] count;
    logic          empty, full, ovf, unf;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state.
    int m_mem [D];
    int m_wp;
    int m_cnt;
    bit m_ovf, m_unf;

    pc_stack #(.DEPTH(D), .PC_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .clr_flags (clr_flags),
        .stack_bus (stack_bus),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < D; i++) m_mem[i] = 0;
        m_wp  = 0;
        m_cnt = 0;
        m_ovf = 0;
        m_unf = 0;
    endfunction

    function automatic int m_top();
        return m_mem[(m_wp + D - 1) % D];
    endfunction

    function automatic void m_step(bit p, bit o, int d, bit c);
        bit so, su;
        so = 0;
        su = 0;
        if (p && o) begin
            m_mem[(m_wp + D - 1) % D] = d;
        end else if (p) begin
            m_mem[m_wp] = d;
            m_wp = (m_wp + 1) % D;
            if (m_cnt == D) so = 1;
            else m_cnt++;
        end else if (o) begin
            m_wp = (m_wp + D - 1) % D;
            if (m_cnt == 0) su = 1;
            else m_cnt--;
        end
        m_ovf = (m_ovf && !c) || so;
        m_unf = (m_unf && !c) || su;
    endfunction

    // Cycle-by-cycle compare against the model.
    always @(posedge clk) begin
        if (rst) m_reset();
        else m_step(push, pop, int'(push_data), clr_flags);
        #1;
        check("bus",   int'(stack_bus), m_top());
        check("count", int'(count), m_cnt);
        check("empty", int'(empty), int'(m_cnt == 0));
        check("full",  int'(full), int'(m_cnt == D));
        check("ovf",   int'(ovf), int'(m_ovf));
        check("unf",   int'(unf), int'(m_unf));
    end

    task automatic drive(bit p, bit o, int d, bit c);
        @(negedge clk);
        push      = p;
        pop       = o;
        push_data = W'(d);
        clr_flags = c;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        m_reset();
        #1;
        check("arst_count", int'(count), 0);
        check("arst_bus",   int'(stack_bus), 0);
        check("arst_empty", int'(empty), 1);
        check("arst_full",  int'(full), 0);
        check("arst_ovf",   int'(ovf), 0);
        check("arst_unf",   int'(unf), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        m_reset();
        #12;
        check("rst_empty", int'(empty), 1);
        check("rst_count", int'(count), 0);
        check("rst_bus",   int'(stack_bus), 0);
        @(negedge clk);
        rst = 1'b0;

        // Two pushes fill the stack.
        drive(1, 0, 'h010, 0);
        drive(1, 0, 'h020, 0);
        drive(0, 0, 0, 0);
        check("d33_bus",   int'(stack_bus), 'h020);
        check("d33_count", int'(count), 2);
        check("d33_full",  int'(full), 1);

        // Two pops; bus valid during the pop cycle.
        drive(0, 1, 0, 0);
        check("d34_bus0", int'(stack_bus), 'h020);
        drive(0, 1, 0, 0);
        check("d34_bus1", int'(stack_bus), 'h010);
        drive(0, 0, 0, 0);
        check("d34_empty", int'(empty), 1);
        check("d34_unf",   int'(unf), 0);

        // Underflow, then clear.
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        check("d36_unf",   int'(unf), 1);
        check("d36_count", int'(count), 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        check("d36_clr", int'(unf), 0);

        // Overflow overwrites the oldest entry.
        drive(1, 0, 'h001, 0);
        drive(1, 0, 'h002, 0);
        drive(1, 0, 'h003, 0);
        drive(0, 0, 0, 0);
        check("d35_ovf",   int'(ovf), 1);
        check("d35_count", int'(count), 2);
        check("d35_bus",   int'(stack_bus), 'h003);
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        check("d35_pop", int'(stack_bus), 'h002);

        // Clear coincident with a new overflow: set wins.
        drive(1, 0, 'h0AA, 0);
        drive(1, 0, 'h0BB, 1);
        drive(0, 0, 0, 0);
        check("setwins_ovf", int'(ovf), 1);

        // Simultaneous push/pop replaces the top.
        async_reset();
        drive(1, 0, 'h010, 0);
        drive(1, 0, 'h020, 0);
        drive(1, 1, 'h1FF, 0);
        drive(0, 0, 0, 0);
        check("d37_bus",   int'(stack_bus), 'h1FF);
        check("d37_count", int'(count), 2);
        check("d37_ovf",   int'(ovf), 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        check("d37_below", int'(stack_bus), 'h010);

        // Mid-cycle async reset with flags set and stack full.
        drive(1, 0, 'h055, 0);
        drive(1, 0, 'h066, 0);
        drive(1, 0, 'h077, 0);
        drive(0, 0, 0, 0);
        check("pre_arst_ovf", int'(ovf), 1);
        async_reset();

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                push = $urandom_range(0, 1);
                pop  = $urandom_range(0, 1);
                async_reset();
            end else begin
                drive($urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, (1 << W) - 1),
                      $urandom_range(0, 7) == 0);
            end
        end
        drive(0, 0, 0, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
